load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-access stage between the MIPS execute stage and `DataMemory`, which is word-addressed, single-port, and either reads or writes each cycle. The block turns byte, halfword and word loads and stores at byte addresses into word accesses. Loads get lane extraction with sign or zero extension. Sub-word stores run as a two-cycle read-modify-write, and the block stalls the pipeline while a multi-cycle access is in flight.

## Interface
- `DATA_WIDTH`, 32, data word width (fixed at 32 for lane logic)
- `ADDR_WIDTH`, 10, word-address width presented to `DataMemory`

Ports:
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-high
- `req_valid` in 1: request present
- `req_write` in 1: 1 = store, 0 = load
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 illegal
- `req_unsigned` in 1: zero-extend loads (lbu/lhu)
- `req_addr` in 32: byte address
- `req_wdata` in 32: store data, right-justified
- `busy` out 1: stall; request not accepted
- `load_valid` out 1: one-cycle pulse, `load_data` valid
- `load_data` out 32: extended load result
- `misaligned` out 1: one-cycle pulse, request rejected
- `mem_address` out ADDR_WIDTH: `req_addr[ADDR_WIDTH+1:2]` or held address
- `mem_dataIn` out 32: write word
- `mem_we` out 1: write enable
- `mem_dataOut` in 32: registered read data, valid the cycle after address

## Operation
- Byte lanes are little-endian: byte offset 0 maps to bits 7:0, halfword offset 2 maps to bits 31:16.
- A request is accepted when `req_valid && !busy`. `busy = (state != IDLE)`. The requester holds the request while `busy` is high.
- FSM states: IDLE, LOAD_WAIT, RMW.
- IDLE, load accepted:
  - Drive the word address with `mem_we`=0.
  - Latch the offset, size and unsigned flag.
  - Go to LOAD_WAIT.
- LOAD_WAIT:
  - Hold `mem_address` and keep `mem_we`=0.
  - Extract the lane from `mem_dataOut` and extend it; sign-extend from bit 7 or bit 15 unless unsigned.
  - Register the result into `load_data`, pulse `load_valid`, and go to IDLE.
- IDLE, word store accepted: single cycle. Drive `mem_we`=1 and `mem_dataIn`=`req_wdata`, and stay in IDLE.
- IDLE, sub-word store accepted:
  - Issue a read with `mem_we`=0.
  - Latch the address, offset, size and `req_wdata[15:0]`.
  - Go to RMW.
- RMW:
  - Drive `mem_we`=1 and `mem_dataIn` = `mem_dataOut` with the addressed lane(s) replaced by the latched data.
  - Go to IDLE.
- Misaligned or illegal requests (half with `addr[0]`=1, word with `addr[1:0]`≠0, or size 11) are accepted but never reach memory. `mem_we` stays 0 and there is no `load_valid`. `misaligned` pulses the next cycle.
- `load_data` holds its value until the next completed load.

## Timing
- Reset values: state IDLE; `load_valid`, `misaligned` and `load_data` are 0; all latched request registers are 0.
- `mem_we` is forced to 0 while `reset` is high.
- Latencies:
  - Load: accepted at cycle N, `load_valid` at N+2. Loads are accepted at most once per 2 cycles.
  - Word store: memory written at the edge ending cycle N.
  - Sub-word store: read in cycle N, write in cycle N+1, `busy` high in N+1.
- A new request may be accepted in the same cycle that `load_valid` pulses.
- Reset asserted in RMW aborts the access. No write occurs.
- Reset asserted in LOAD_WAIT drops the access with no `load_valid`.
- `mem_address` is combinational from `req_addr` in IDLE and from the held address otherwise.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: misalignment detection as described in Operation.
- `LSU_MISALIGN_TRAP_EN` undefined:
  - `misaligned` is tied to 0.
  - Halfword offsets are forced even (`addr[0]` ignored) and word accesses ignore `addr[1:0]`.
  - Size 11 is treated as word.

## Structure
- Package `lsu_pkg` holds:
  - size encodings (`LSU_BYTE`, `LSU_HALF`, `LSU_WORD`)
  - the FSM state enum
  - lane-select constants
- Sub-module `lsu_byte_lane` (combinational) holds load extract/extend and store merge. It is shared by LOAD_WAIT and RMW.

## Test plan
- Word store then load:
  - Stimulus: sw 0x12345678 @0x400, then lw @0x400.
  - Response: `mem_address`=0x100 with `mem_we`=1 for one cycle, then `load_valid` 2 cycles after acceptance with `load_data`=0x12345678.
- Signed and unsigned byte loads after the same preload:
  - Stimulus: lb @0x401, lbu @0x403, lh @0x402.
  - Response: 0x00000056, 0x00000012, 0x00001234.
- Sign extension:
  - Stimulus: preload 0x80F0FF80, then lb @0x400, lbu @0x400, lh @0x402.
  - Response: 0xFFFFFF80, 0x00000080, 0xFFFF80F0.
- Sub-word RMW:
  - Stimulus: sb 0xAB @0x401, sh 0xBEEF @0x402 on word 0x12345678.
  - Response: `busy` high one cycle per store, and a subsequent lw returns 0xBEEFAB78.
- Misalignment with `LSU_MISALIGN_TRAP_EN`:
  - Stimulus: lw @0x402, sh @0x401.
  - Response: `misaligned` pulses once each, `mem_we` never 1, no `load_valid`, memory unchanged.
- Reset mid-RMW:
  - Stimulus: sb 0xFF @0x400, with `reset` asserted during RMW.
  - Response: `mem_we` stays 0, state is IDLE after reset, and a subsequent lw returns the unmodified word.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: size encodings, FSM states and lane geometry shared by the load/store unit.
package lsu_pkg;
  localparam logic [1:0] LSU_BYTE = 2'b00;
  localparam logic [1:0] LSU_HALF = 2'b01;
  localparam logic [1:0] LSU_WORD = 2'b10;
  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;
  typedef enum logic [1:0] {IDLE, LOAD_WAIT, RMW} lsu_state_e;
endpackage

// File: rtl/lsu_byte_lane.sv
// lsu_byte_lane: little-endian lane extract/extend for loads and lane merge for sub-word stores.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        zext,
  input  logic [31:0] rdata,
  input  logic [15:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = rdata[offset*BYTE_W +: BYTE_W];
    h = offset[1] ? rdata[31:16] : rdata[15:0];
    load_data = size == LSU_BYTE ? {{24{b[7] & ~zext}}, b} :
                size == LSU_HALF ? {{16{h[15] & ~zext}}, h} : rdata;
    merged = rdata;
    if (size == LSU_BYTE)
      merged[offset*BYTE_W +: BYTE_W] = wdata[7:0];
    else if (size == LSU_HALF)
      merged[offset[1]*HALF_W +: HALF_W] = wdata;
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word loads and stores onto a word-addressed single-port memory.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned/illegal requests via the misaligned pulse.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  busy,
  output logic                  load_valid,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic                  misaligned,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_dataIn,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_dataOut
);
  lsu_state_e state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0] off_q, size_q;
  logic uns_q;
  logic [15:0] wdata_q;
  logic accept, bad, go;
  logic [1:0] size_eff;
  logic [31:0] lane_load, lane_merge;
  logic unused_addr;
  assign unused_addr = ^req_addr[31:ADDR_WIDTH+2];
`ifdef LSU_MISALIGN_TRAP_EN
  assign size_eff = req_size;
  assign bad = req_size == 2'b11 || (req_size == LSU_HALF && req_addr[0]) ||
               (req_size == LSU_WORD && req_addr[1:0] != 2'b00);
`else
  assign size_eff = req_size == 2'b11 ? LSU_WORD : req_size;
  assign bad = 1'b0;
`endif
  assign busy = state != IDLE;
  assign accept = req_valid && !busy;
  assign go = accept && !bad;
  always_comb begin
    state_nxt = go && (!req_write || size_eff != LSU_WORD) ? (req_write ? RMW : LOAD_WAIT) : IDLE;
    mem_address = state == IDLE ? req_addr[ADDR_WIDTH+1:2] : addr_q;
    mem_we = !reset && (state == RMW || (go && req_write && size_eff == LSU_WORD));
    mem_dataIn = state == RMW ? lane_merge : req_wdata;
  end
  lsu_byte_lane u_lane (
    .size(size_q),
    .offset(off_q),
    .zext(uns_q),
    .rdata(mem_dataOut),
    .wdata(wdata_q),
    .load_data(lane_load),
    .merged(lane_merge)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      load_valid <= 1'b0;
      misaligned <= 1'b0;
      load_data <= '0;
      addr_q <= '0;
      off_q <= '0;
      size_q <= '0;
      uns_q <= 1'b0;
      wdata_q <= '0;
    end else begin
      state <= state_nxt;
      load_valid <= state == LOAD_WAIT;
      misaligned <= accept && bad;
      if (state == LOAD_WAIT) load_data <= lane_load;
      if (accept) begin
        addr_q <= req_addr[ADDR_WIDTH+1:2];
        off_q <= req_addr[1:0];
        size_q <= size_eff;
        uns_q <= req_unsigned;
        wdata_q <= req_wdata[15:0];
      end
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed stimulus with a scoreboard monitor for loads, writes and misalign pulses.
module tb_load_store_unit;
  logic clk = 0, reset = 1;
  logic req_valid = 0, req_write = 0, req_unsigned = 0;
  logic [1:0] req_size = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic busy, load_valid, misaligned, mem_we;
  logic [31:0] load_data, mem_dataIn, mem_dataOut;
  logic [9:0] mem_address;
  logic [31:0] mem [0:1023];
  int checks = 0, errors = 0, mis_exp = 0;
  logic [31:0] lq[$], wdq[$];
  logic [9:0] waq[$];

  localparam int LD = 0, SW = 1, SUB = 2, MIS = 3;

  load_store_unit dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .busy(busy), .load_valid(load_valid), .load_data(load_data),
    .misaligned(misaligned), .mem_address(mem_address), .mem_dataIn(mem_dataIn),
    .mem_we(mem_we), .mem_dataOut(mem_dataOut)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < 1024; i++) mem[i] = '0;
  always @(posedge clk) begin
    if (mem_we) mem[mem_address] <= mem_dataIn;
    mem_dataOut <= mem[mem_address];
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (mem_we) begin
      if (waq.size() == 0) check("unexpected_write", {22'd0, mem_address}, 32'hFFFF_FFFF);
      else begin
        check("wr_addr", {22'd0, mem_address}, {22'd0, waq.pop_front()});
        check("wr_data", mem_dataIn, wdq.pop_front());
      end
    end
    if (load_valid) begin
      if (lq.size() == 0) check("unexpected_load", load_data, 32'hFFFF_FFFF);
      else check("load_data", load_data, lq.pop_front());
    end
    if (misaligned) begin
      if (mis_exp == 0) check("unexpected_misaligned", 1, 0);
      else begin
        mis_exp--;
        check("misaligned_pulse", 1, 1);
      end
    end
  end

  task automatic issue(input int kind, input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp);
    int n = 0;
    while (busy && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("accept_wait", {31'd0, busy}, 0);
    if (kind == LD) lq.push_back(exp);
    if (kind == SW || kind == SUB) begin
      waq.push_back(a[11:2]);
      wdq.push_back(exp);
    end
    if (kind == MIS) mis_exp++;
    req_valid = 1; req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = d;
    @(posedge clk); #1;
    req_valid = 0;
    check("busy_after", {31'd0, busy}, {31'd0, kind == LD || kind == SUB});
    if (kind == LD || kind == SUB) begin
      @(posedge clk); #1;
      check("busy_clear", {31'd0, busy}, 0);
      if (kind == LD) check("load_latency", {31'd0, load_valid}, 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    req_valid = 1; req_write = 1; req_size = 2'b10; req_addr = 32'h400; req_wdata = 32'hDEADBEEF;
    @(posedge clk); @(posedge clk); #1;
    check("rst_mem_we", {31'd0, mem_we}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_load_valid", {31'd0, load_valid}, 0);
    check("rst_misaligned", {31'd0, misaligned}, 0);
    check("rst_load_data", load_data, 0);
    check("rst_mem_address", {22'd0, mem_address}, 32'h100);
    req_valid = 0;
    reset = 0;
    @(posedge clk); #1;
    // word store then loads of every lane shape
    issue(SW, 1, 2'b10, 0, 32'h400, 32'h12345678, 32'h12345678);
    issue(LD, 0, 2'b10, 0, 32'h400, 0, 32'h12345678);
    issue(LD, 0, 2'b00, 0, 32'h401, 0, 32'h00000056);
    issue(LD, 0, 2'b00, 1, 32'h403, 0, 32'h00000012);
    issue(LD, 0, 2'b01, 0, 32'h402, 0, 32'h00001234);
    issue(LD, 0, 2'b01, 1, 32'h400, 0, 32'h00005678);
    issue(LD, 0, 2'b00, 0, 32'h400, 0, 32'h00000078);
    // sub-word read-modify-write
    issue(SUB, 1, 2'b00, 0, 32'h401, 32'hFFFFFFAB, 32'h1234AB78);
    issue(SUB, 1, 2'b01, 0, 32'h402, 32'h1111BEEF, 32'hBEEFAB78);
    issue(LD, 0, 2'b10, 0, 32'h400, 0, 32'hBEEFAB78);
    // sign extension
    issue(SW, 1, 2'b10, 0, 32'h400, 32'h80F0FF80, 32'h80F0FF80);
    issue(LD, 0, 2'b00, 0, 32'h400, 0, 32'hFFFFFF80);
    issue(LD, 0, 2'b00, 1, 32'h400, 0, 32'h00000080);
    issue(LD, 0, 2'b01, 0, 32'h402, 0, 32'hFFFF80F0);
    issue(LD, 0, 2'b01, 1, 32'h402, 0, 32'h000080F0);
    issue(LD, 0, 2'b00, 0, 32'h402, 0, 32'hFFFFFFF0);
    issue(LD, 0, 2'b01, 0, 32'h400, 0, 32'hFFFFFF80);
    issue(LD, 0, 2'b00, 0, 32'h401, 0, 32'hFFFFFFFF);
`ifdef LSU_MISALIGN_TRAP_EN
    issue(MIS, 0, 2'b10, 0, 32'h402, 0, 0);
    issue(MIS, 1, 2'b01, 0, 32'h401, 32'h5555, 0);
    issue(MIS, 0, 2'b11, 0, 32'h400, 0, 0);
    issue(MIS, 1, 2'b11, 0, 32'h400, 32'h01020304, 0);
    issue(LD, 0, 2'b10, 0, 32'h400, 0, 32'h80F0FF80);
`else
    issue(LD, 0, 2'b01, 0, 32'h403, 0, 32'hFFFF80F0);
    issue(LD, 0, 2'b10, 0, 32'h402, 0, 32'h80F0FF80);
    issue(LD, 0, 2'b11, 0, 32'h400, 0, 32'h80F0FF80);
    issue(SUB, 1, 2'b01, 0, 32'h401, 32'h00001234, 32'h80F01234);
    issue(LD, 0, 2'b10, 0, 32'h400, 0, 32'h80F01234);
    issue(SW, 1, 2'b11, 0, 32'h401, 32'hCAFEF00D, 32'hCAFEF00D);
    issue(LD, 0, 2'b10, 0, 32'h400, 0, 32'hCAFEF00D);
    issue(SW, 1, 2'b10, 0, 32'h400, 32'h80F0FF80, 32'h80F0FF80);
`endif
    // reset while the RMW write is pending
    req_valid = 1; req_write = 1; req_size = 2'b00; req_unsigned = 0; req_addr = 32'h400; req_wdata = 32'hFF;
    @(posedge clk); #1;
    check("rmw_busy", {31'd0, busy}, 1);
    reset = 1; req_valid = 0;
    #1;
    check("rmw_rst_we", {31'd0, mem_we}, 0);
    check("rmw_rst_idle", {31'd0, busy}, 0);
    @(posedge clk); #1;
    check("rmw_rst_load_data", load_data, 0);
    reset = 0;
    @(posedge clk); #1;
    issue(LD, 0, 2'b10, 0, 32'h400, 0, 32'h80F0FF80);
    repeat (4) @(posedge clk);
    #1;
    check("load_q_empty", lq.size(), 0);
    check("write_q_empty", waq.size(), 0);
    check("misaligned_pending", mis_exp, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
